// File: rtl/tetris_move_sequencer_pkg.sv
// Shared definitions for the Tetris move sequencer: FSM state encoding,
// action codes and default board geometry.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SPAWN     = 3'd1,
        ST_SPAWN_CHK = 3'd2,
        ST_FALL      = 3'd3,
        ST_CHECK     = 3'd4,
        ST_LOCK      = 3'd5,
        ST_OVER      = 3'd6
    } state_t;

    // Action codes double as bit positions in the arbiter's one-hot grant.
    typedef enum logic [1:0] {
        ACT_L = 2'd0,
        ACT_R = 2'd1,
        ACT_T = 2'd2,
        ACT_G = 2'd3
    } act_t;

    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 20;
    localparam int DEF_SPAWN_X = 4;
    localparam int DEF_SPAWN_Y = 0;

endpackage

// File: rtl/tetris_move_sequencer_arbiter.sv
// Pending-action latch for left/right/rotate/gravity with left+right
// cancellation and fixed-priority (L > R > T > G) one-hot grant.
module tetris_action_arbiter
    import tetris_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic       i_take,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_rot,
    input  logic       i_tick,
    output logic [3:0] o_grant,
    output logic       o_any
);

    logic [3:0] r_pending;
    logic [3:0] w_set;
    logic [3:0] w_next;

    always_comb begin
        w_set = 4'b0000;
        if (i_enable) begin
            w_set[ACT_L] = i_left & ~i_right;
            w_set[ACT_R] = i_right & ~i_left;
            w_set[ACT_T] = i_rot;
            w_set[ACT_G] = i_tick;
        end

        o_grant = 4'b0000;
        if (r_pending[ACT_L])      o_grant[ACT_L] = 1'b1;
        else if (r_pending[ACT_R]) o_grant[ACT_R] = 1'b1;
        else if (r_pending[ACT_T]) o_grant[ACT_T] = 1'b1;
        else if (r_pending[ACT_G]) o_grant[ACT_G] = 1'b1;
        o_any = |r_pending;

        // A pulse landing in the same cycle its bit is consumed stays latched.
        if (i_clear)
            w_next = 4'b0000;
        else
            w_next = (r_pending & ~(i_take ? o_grant : 4'b0000)) | w_set;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pending <= 4'b0000;
        else
            r_pending <= w_next;
    end

endmodule

// File: rtl/tetris_move_sequencer.sv
// Game-flow controller: owns the active piece, serialises move/gravity
// requests through the collision checker, drives locking, score and game over.
module tetris_move_sequencer
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int SPAWN_X = DEF_SPAWN_X,
    parameter int SPAWN_Y = DEF_SPAWN_Y
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        left_final,
    input  logic        right_final,
    input  logic        rot_final,
    input  logic        tick_gravity,
    input  logic [2:0]  next_shape,
    output logic        chk_req,
    output logic [4:0]  chk_x,
    output logic [4:0]  chk_y,
    output logic [1:0]  chk_rot,
    output logic [2:0]  chk_shape,
    input  logic        chk_done,
    input  logic        chk_collide,
    output logic        lock_req,
    input  logic        lock_done,
    input  logic [2:0]  lines_in,
    output logic [4:0]  piece_x,
    output logic [4:0]  piece_y,
    output logic [1:0]  rot,
    output logic [2:0]  shape_id,
    output logic [2:0]  state,
    output logic        move_accept,
    output logic        lock_phase,
    output logic [15:0] score,
    output logic        game_over
);

    localparam logic [4:0] LP_XMAX   = 5'(BOARD_W - 1);
    localparam logic [4:0] LP_YMAX   = 5'(BOARD_H - 1);
    localparam logic [4:0] LP_SPAWNX = 5'(SPAWN_X);
    localparam logic [4:0] LP_SPAWNY = 5'(SPAWN_Y);

    state_t      r_state, w_next_state;
    act_t        r_act, w_act;
    logic        r_chk_req, r_lock_req, r_move_accept;
    logic [4:0]  r_cand_x, r_cand_y, w_cand_x, w_cand_y;
    logic [1:0]  r_cand_rot, w_cand_rot;
    logic [4:0]  r_piece_x, r_piece_y;
    logic [1:0]  r_rot;
    logic [2:0]  r_shape;
    logic [15:0] r_score;
    logic [16:0] w_sum;
    logic [3:0]  w_grant;
    logic        w_any, w_take, w_clear, w_enable;
    logic        w_issue, w_commit, w_start_lock, w_done, w_lock_done;

    assign w_done      = chk_done & r_chk_req;
    assign w_lock_done = lock_done & r_lock_req;
    assign w_enable    = (r_state != ST_IDLE) && (r_state != ST_OVER);
    assign w_clear     = (w_next_state == ST_SPAWN) && (r_state != ST_SPAWN);
    assign w_sum       = {1'b0, r_score} + 17'(lines_in);

    tetris_action_arbiter u_arbiter (
        .i_clk    (CLOCK_50),
        .i_rst_n  (resetn),
        .i_enable (w_enable),
        .i_clear  (w_clear),
        .i_take   (w_take),
        .i_left   (left_final),
        .i_right  (right_final),
        .i_rot    (rot_final),
        .i_tick   (tick_gravity),
        .o_grant  (w_grant),
        .o_any    (w_any)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_act        = r_act;
        w_cand_x     = r_piece_x;
        w_cand_y     = r_piece_y;
        w_cand_rot   = r_rot;
        w_issue      = 1'b0;
        w_take       = 1'b0;
        w_commit     = 1'b0;
        w_start_lock = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_SPAWN;
            ST_SPAWN: begin
                w_cand_x     = LP_SPAWNX;
                w_cand_y     = LP_SPAWNY;
                w_cand_rot   = 2'd0;
                w_issue      = 1'b1;
                w_next_state = ST_SPAWN_CHK;
            end
            ST_SPAWN_CHK: if (w_done) begin
                if (chk_collide) begin
                    w_next_state = ST_OVER;
                end else begin
                    w_commit     = 1'b1;
                    w_next_state = ST_FALL;
                end
            end
            // Edge moves are dropped silently; a floor-level tick locks at once.
            ST_FALL: if (w_any) begin
                w_take = 1'b1;
                if (w_grant[ACT_L]) begin
                    w_act = ACT_L;
                    if (r_piece_x != 5'd0) begin
                        w_cand_x = r_piece_x - 5'd1;
                        w_issue  = 1'b1;
                    end
                end else if (w_grant[ACT_R]) begin
                    w_act = ACT_R;
                    if (r_piece_x != LP_XMAX) begin
                        w_cand_x = r_piece_x + 5'd1;
                        w_issue  = 1'b1;
                    end
                end else if (w_grant[ACT_T]) begin
                    w_act      = ACT_T;
                    w_cand_rot = r_rot + 2'd1;
                    w_issue    = 1'b1;
                end else begin
                    w_act = ACT_G;
                    if (r_piece_y == LP_YMAX) begin
                        w_start_lock = 1'b1;
                        w_next_state = ST_LOCK;
                    end else begin
                        w_cand_y = r_piece_y + 5'd1;
                        w_issue  = 1'b1;
                    end
                end
                if (w_issue) w_next_state = ST_CHECK;
            end
            ST_CHECK: if (w_done) begin
                if (!chk_collide) begin
                    w_commit     = 1'b1;
                    w_next_state = ST_FALL;
                end else if (r_act == ACT_G) begin
                    w_start_lock = 1'b1;
                    w_next_state = ST_LOCK;
                end else begin
                    w_next_state = ST_FALL;
                end
            end
            ST_LOCK: if (w_lock_done) w_next_state = ST_SPAWN;
            ST_OVER: if (start) w_next_state = ST_SPAWN;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_act         <= ACT_G;
            r_chk_req     <= 1'b0;
            r_lock_req    <= 1'b0;
            r_move_accept <= 1'b0;
            r_cand_x      <= LP_SPAWNX;
            r_cand_y      <= LP_SPAWNY;
            r_cand_rot    <= 2'd0;
            r_piece_x     <= LP_SPAWNX;
            r_piece_y     <= LP_SPAWNY;
            r_rot         <= 2'd0;
            r_shape       <= 3'd0;
            r_score       <= 16'd0;
        end else begin
            r_move_accept <= w_commit;
            if (w_issue) begin
                r_chk_req  <= 1'b1;
                r_act      <= w_act;
                r_cand_x   <= w_cand_x;
                r_cand_y   <= w_cand_y;
                r_cand_rot <= w_cand_rot;
            end else if (w_done) begin
                r_chk_req <= 1'b0;
            end
            if (w_commit) begin
                r_piece_x <= r_cand_x;
                r_piece_y <= r_cand_y;
                r_rot     <= r_cand_rot;
            end
            if (r_state == ST_SPAWN)
                r_shape <= next_shape;
            if (w_start_lock) begin
                r_lock_req <= 1'b1;
            end else if (w_lock_done) begin
                r_lock_req <= 1'b0;
                r_score    <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
            end
            if (r_state == ST_OVER && start)
                r_score <= 16'd0;
        end
    end

    assign chk_req     = r_chk_req;
    assign chk_x       = r_cand_x;
    assign chk_y       = r_cand_y;
    assign chk_rot     = r_cand_rot;
    assign chk_shape   = r_shape;
    assign lock_req    = r_lock_req;
    assign piece_x     = r_piece_x;
    assign piece_y     = r_piece_y;
    assign rot         = r_rot;
    assign shape_id    = r_shape;
    assign state       = r_state;
    assign move_accept = r_move_accept;
    assign lock_phase  = (r_state == ST_LOCK);
    assign score       = r_score;
    assign game_over   = (r_state == ST_OVER);

endmodule

// File: tb/tb_tetris_move_sequencer.sv
// Directed bench for tetris_move_sequencer: spawn, gravity, move priority,
// edge drop, lock/score, game over and asynchronous reset mid-check.
module tb_tetris_move_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        resetn, start, left_final, right_final, rot_final, tick_gravity;
    logic [2:0]  next_shape;
    logic        chk_req, chk_done, chk_collide;
    logic [4:0]  chk_x, chk_y;
    logic [1:0]  chk_rot;
    logic [2:0]  chk_shape;
    logic        lock_req, lock_done;
    logic [2:0]  lines_in;
    logic [4:0]  piece_x, piece_y;
    logic [1:0]  rot;
    logic [2:0]  shape_id, state;
    logic        move_accept, lock_phase, game_over;
    logic [15:0] score;

    int errors = 0;
    int checks = 0;
    int acceptCount = 0;
    int reqCount = 0;
    int baseAcc, baseReq;
    logic prevReq = 1'b0;

    tetris_move_sequencer dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .start        (start),
        .left_final   (left_final),
        .right_final  (right_final),
        .rot_final    (rot_final),
        .tick_gravity (tick_gravity),
        .next_shape   (next_shape),
        .chk_req      (chk_req),
        .chk_x        (chk_x),
        .chk_y        (chk_y),
        .chk_rot      (chk_rot),
        .chk_shape    (chk_shape),
        .chk_done     (chk_done),
        .chk_collide  (chk_collide),
        .lock_req     (lock_req),
        .lock_done    (lock_done),
        .lines_in     (lines_in),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .rot          (rot),
        .shape_id     (shape_id),
        .state        (state),
        .move_accept  (move_accept),
        .lock_phase   (lock_phase),
        .score        (score),
        .game_over    (game_over)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Count accept pulses and request rising edges as seen at each active edge.
    always @(posedge CLOCK_50) begin
        if (move_accept) acceptCount++;
        if (chk_req && !prevReq) reqCount++;
        prevReq = chk_req;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic ro, input logic g);
        left_final   = l;
        right_final  = r;
        rot_final    = ro;
        tick_gravity = g;
        @(negedge CLOCK_50);
        left_final   = 1'b0;
        right_final  = 1'b0;
        rot_final    = 1'b0;
        tick_gravity = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (!chk_req && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!chk_req) checkOutput({tag, "_timeout"}, 32'(chk_req), 32'd1);
    endtask

    task automatic answerCheck(input logic collide, input logic [4:0] ex, input logic [4:0] ey,
                               input logic [1:0] er, input string tag);
        waitReq(tag);
        checkOutput({tag, "_x"}, 32'(chk_x), 32'(ex));
        checkOutput({tag, "_y"}, 32'(chk_y), 32'(ey));
        checkOutput({tag, "_rot"}, 32'(chk_rot), 32'(er));
        chk_done    = 1'b1;
        chk_collide = collide;
        @(negedge CLOCK_50);
        chk_done    = 1'b0;
        chk_collide = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; left_final = 1'b0; right_final = 1'b0;
        rot_final = 1'b0; tick_gravity = 1'b0; next_shape = 3'd3;
        chk_done = 1'b0; chk_collide = 1'b0; lock_done = 1'b0; lines_in = 3'd0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_px", 32'(piece_x), 32'd4);
        checkOutput("rst_py", 32'(piece_y), 32'd0);
        checkOutput("rst_req", 32'(chk_req), 32'd0);
        checkOutput("rst_lockreq", 32'(lock_req), 32'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        $display("[TB] spawn with shape 3");
        baseAcc = acceptCount;
        pulseStart();
        answerCheck(1'b0, 5'd4, 5'd0, 2'd0, "spawn");
        checkOutput("spawn_state", 32'(state), 32'd3);
        checkOutput("spawn_shape", 32'(shape_id), 32'd3);
        checkOutput("spawn_px", 32'(piece_x), 32'd4);
        checkOutput("spawn_py", 32'(piece_y), 32'd0);
        checkOutput("spawn_acc", 32'(acceptCount - baseAcc), 32'd1);

        $display("[TB] six gravity ticks");
        baseAcc = acceptCount;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            answerCheck(1'b0, 5'd4, 5'(i), 2'd0, $sformatf("grav%0d", i));
        end
        checkOutput("grav_py", 32'(piece_y), 32'd6);
        checkOutput("grav_acc", 32'(acceptCount - baseAcc), 32'd6);

        $display("[TB] left and rotate together");
        baseAcc = acceptCount;
        baseReq = reqCount;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        answerCheck(1'b0, 5'd3, 5'd6, 2'd0, "lr_left");
        answerCheck(1'b0, 5'd3, 5'd6, 2'd1, "lr_rot");
        checkOutput("lr_px", 32'(piece_x), 32'd3);
        checkOutput("lr_rot_c", 32'(rot), 32'd1);
        checkOutput("lr_reqs", 32'(reqCount - baseReq), 32'd2);
        checkOutput("lr_acc", 32'(acceptCount - baseAcc), 32'd2);

        $display("[TB] walk to the left wall");
        for (int x = 2; x >= 0; x--) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            answerCheck(1'b0, 5'(x), 5'd6, 2'd1, $sformatf("walk%0d", x));
        end
        baseAcc = acceptCount;
        baseReq = reqCount;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        checkOutput("wall_reqs", 32'(reqCount - baseReq), 32'd0);
        checkOutput("wall_acc", 32'(acceptCount - baseAcc), 32'd0);
        checkOutput("wall_px", 32'(piece_x), 32'd0);
        checkOutput("wall_state", 32'(state), 32'd3);

        $display("[TB] gravity collide, lock with two lines");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        answerCheck(1'b1, 5'd0, 5'd7, 2'd1, "lockchk");
        checkOutput("lock_state", 32'(state), 32'd5);
        checkOutput("lock_phase", 32'(lock_phase), 32'd1);
        checkOutput("lock_req", 32'(lock_req), 32'd1);
        checkOutput("lock_py", 32'(piece_y), 32'd6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        next_shape = 3'd5;
        lock_done = 1'b1;
        lines_in  = 3'd2;
        @(negedge CLOCK_50);
        lock_done = 1'b0;
        lines_in  = 3'd0;
        checkOutput("lock_score", 32'(score), 32'd2);
        checkOutput("respawn_state", 32'(state), 32'd1);
        answerCheck(1'b0, 5'd4, 5'd0, 2'd0, "respawn");
        checkOutput("respawn_shape", 32'(shape_id), 32'd5);
        baseReq = reqCount;
        repeat (5) @(negedge CLOCK_50);
        checkOutput("respawn_noreq", 32'(reqCount - baseReq), 32'd0);
        checkOutput("respawn_px", 32'(piece_x), 32'd4);

        $display("[TB] spawn collision leads to game over");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        answerCheck(1'b1, 5'd4, 5'd1, 2'd0, "lock2chk");
        lock_done = 1'b1;
        @(negedge CLOCK_50);
        lock_done = 1'b0;
        answerCheck(1'b1, 5'd4, 5'd0, 2'd0, "overchk");
        checkOutput("over_state", 32'(state), 32'd6);
        checkOutput("over_flag", 32'(game_over), 32'd1);
        checkOutput("over_score", 32'(score), 32'd2);
        pulseStart();
        checkOutput("restart_state", 32'(state), 32'd1);
        checkOutput("restart_score", 32'(score), 32'd0);
        answerCheck(1'b0, 5'd4, 5'd0, 2'd0, "restart");

        $display("[TB] reset during check");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        answerCheck(1'b0, 5'd4, 5'd1, 2'd0, "pre_rst");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitReq("mid_rst");
        checkOutput("mid_state", 32'(state), 32'd4);
        resetn = 1'b0;
        #1;
        checkOutput("arst_state", 32'(state), 32'd0);
        checkOutput("arst_req", 32'(chk_req), 32'd0);
        checkOutput("arst_py", 32'(piece_y), 32'd0);
        checkOutput("arst_shape", 32'(shape_id), 32'd0);
        checkOutput("arst_over", 32'(game_over), 32'd0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        chk_done = 1'b1;
        @(negedge CLOCK_50);
        chk_done = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("late_state", 32'(state), 32'd0);
        checkOutput("late_acc", 32'(move_accept), 32'd0);
        checkOutput("late_py", 32'(piece_y), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tetris_move_sequencer.md
Name: tetris_move_sequencer

Overview:
- Game-flow controller that owns the active piece (position, rotation, shape).
- Latches the debounced move pulses and gravity ticks, and serialises them one at a time through the shared collision checker.
- Commits accepted moves, drives locking and score accumulation, and detects game over.
- Sits between the input debouncers / gravity timer and the collision checker and board writer.

Parameters:
- BOARD_W, 10, board width in cells.
- BOARD_H, 20, board height in cells.
- SPAWN_X, 4, spawn column.
- SPAWN_Y, 0, spawn row.

Ports:
- CLOCK_50  in  1  system clock, single clock domain.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE or OVER.
- left_final  in  1  one-cycle debounced left pulse.
- right_final  in  1  one-cycle debounced right pulse.
- rot_final  in  1  one-cycle debounced rotate pulse.
- tick_gravity  in  1  one-cycle gravity pulse.
- next_shape  in  3  shape to spawn next (0-6).
- chk_req  out  1  collision-check request.
- chk_x  out  5  candidate column.
- chk_y  out  5  candidate row.
- chk_rot  out  2  candidate rotation.
- chk_shape  out  3  candidate shape.
- chk_done  in  1  check complete, one cycle.
- chk_collide  in  1  result; valid only with chk_done.
- lock_req  out  1  request to write the piece into the board.
- lock_done  in  1  board write and line clear complete, one cycle.
- lines_in  in  3  lines cleared; valid with lock_done.
- piece_x  out  5  committed piece column.
- piece_y  out  5  committed piece row.
- rot  out  2  committed piece rotation.
- shape_id  out  3  committed piece shape.
- state  out  3  current FSM state.
- move_accept  out  1  one-cycle pulse per committed move.
- lock_phase  out  1  high while in LOCK.
- score  out  16  accumulated lines.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, pending=0, all strobes 0.
  - piece_x=SPAWN_X, piece_y=SPAWN_Y, rot=0, shape_id=0, score=0.
  - Reset mid-handshake drops chk_req/lock_req immediately; late chk_done/lock_done are ignored.
- State encoding:
  - IDLE=0, SPAWN=1, SPAWN_CHK=2, FALL=3, CHECK=4, LOCK=5, OVER=6.
- Pending latch:
  - Bits L, R, T, G are set by their pulses in every state except IDLE and OVER.
  - All bits clear on entry to SPAWN.
  - If left_final and right_final arrive in the same cycle, they cancel: neither bit changes.
- IDLE:
  - On start, go to SPAWN.
- SPAWN (1 cycle):
  - shape_id<=next_shape.
  - Candidate = (SPAWN_X, SPAWN_Y, rot 0).
  - Assert chk_req and go to SPAWN_CHK.
- Request handshake:
  - chk_req is registered and held high until the edge that samples chk_done.
  - chk_x/y/rot/shape are stable while chk_req is high.
  - chk_done with chk_req low is ignored.
- SPAWN_CHK, on chk_done:
  - collide: go to OVER.
  - no collide: commit the candidate, pulse move_accept, go to FALL.
- FALL: pick the highest-priority pending bit (L > R > T > G) and clear it.
  - L: x-1. If piece_x==0, drop it with no check and no accept.
  - R: x+1. If piece_x==BOARD_W-1, drop it.
  - T: rot+1 mod 4 (3 wraps to 0).
  - G: y+1. If piece_y==BOARD_H-1, go directly to LOCK with no check.
  - Otherwise assert chk_req next edge and go to CHECK.
  - Only one action is in flight at a time.
  - Latency: a pulse sampled at edge t gives chk_req high after edge t+1.
- CHECK, on chk_done:
  - no collide: commit the candidate to piece_*; move_accept=1 for exactly the next cycle; go to FALL.
  - collide with action G: go to LOCK.
  - collide with any other action: discard, go to FALL.
  - Pulses arriving during CHECK are latched, including the same type as the one in flight.
- LOCK:
  - lock_phase=1; lock_req is held high until lock_done.
  - On lock_done: score<=score+lines_in, saturating at 16'hFFFF; go to SPAWN.
- OVER:
  - game_over=1.
  - On start: score<=0, go to SPAWN.
- piece_* change only on commit.
- Width rules: all coordinate arithmetic is 5-bit; boundary guards prevent wrap.

Decomposition:
- tetris_pkg holds:
  - the state encoding;
  - action codes ACT_L/ACT_R/ACT_T/ACT_G;
  - default BOARD_W/BOARD_H/SPAWN_X/SPAWN_Y.
- Sub-module tetris_action_arbiter: the pending-bit latch, cancel rule and fixed-priority pick. Outputs a one-hot grant plus an any-pending flag.

Test Plan:
- Reset, start, next_shape=3, chk_done with collide=0 → state=FALL; piece=(4,0,rot 0,shape 3); one move_accept pulse.
- 6 tick_gravity pulses, each answered with no collide → piece_y=6, exactly 6 move_accept pulses, chk_y sequence 1..6.
- left_final and rot_final in the same cycle from (4,6,0) → left checked first; then x=3, rot=1; two sequential chk_req handshakes.
- left at piece_x=0 → no chk_req, no move_accept; piece unchanged.
- Gravity with collide=1 → LOCK, lock_phase=1; lock_done with lines_in=2 → score=2; re-enter SPAWN with pending cleared.
- Spawn collide=1 → game_over=1, state=6.
- Assert resetn low during CHECK → all outputs at reset values within the same cycle.
